riscoffee_mem_arbiter: RTL and testbench
========================================

// Module: riscoffee_mem_arbiter
// PURPOSE
//  Shares the single-port synchronous instruction/data RAM between the IF (fetch) and MA (load/store) requesters of
//  the 5-stage core. Grants one request per cycle, with MA priority and a starvation guard for IF. Drives the RAM
//  port and routes the 1-cycle-latency read data back to the requester that issued the read.
//  Sits between the pipeline stages and the RAM; replaces the ad-hoc store-stall path in the core.
// PARAMETERS
//  ADDR_W         14  RAM word-address width; MEM_ADDR = byte address [ADDR_W+1:2]
//  MAX_MA_STREAK  4   consecutive contended MA grants before IF is forced one grant; legal range 1..15
// PORTS
//  CLK          in   1   clock, rising edge
//  RST_N        in   1   reset, synchronous, active-low
//  IF_REQ       in   1   fetch read request
//  IF_ADDR      in   32  fetch byte address (word-aligned)
//  IF_FLUSH     in   1   discard any outstanding fetch response (taken jump/branch)
//  IF_GNT       out  1   fetch request accepted this cycle
//  IF_RVALID    out  1   fetch read data valid
//  IF_RDATA     out  32  fetch read data
//  MA_REQ       in   1   data request
//  MA_WE        in   1   1 = store, 0 = load
//  MA_BE        in   4   store byte enables (ignored for loads)
//  MA_ADDR      in   32  data byte address
//  MA_WDATA     in   32  store data, already lane-aligned
//  MA_GNT       out  1   data request accepted this cycle
//  MA_RVALID    out  1   load data valid
//  MA_RDATA     out  32  load data (full word; lane extraction by requester)
//  MEM_EN       out  1   RAM access enable
//  MEM_WE       out  4   RAM byte write enables
//  MEM_ADDR     out  ADDR_W  RAM word address
//  MEM_WDATA    out  32  RAM write data
//  MEM_RDATA    in   32  RAM read data, valid the cycle after a read access
//  PERF_IF_WAIT out  32  cycles IF_REQ=1 and IF_GNT=0 (optional feature)
//  PERF_MA_GNT  out  32  count of MA grants (optional feature)
// BEHAVIOUR
//  - Grant is combinational, same cycle as request; a request is accepted when REQ & GNT. Requesters hold REQ/ADDR
//    until granted. MEM_* are combinational from the granted requester; MEM_EN=0, MEM_WE=0 when no grant.
//  - Arbitration: only one requester -> it wins. Both -> MA wins, unless streak_cnt == MAX_MA_STREAK, then IF wins.
//  - streak_cnt (4b): +1 on each contended MA grant (saturating at MAX_MA_STREAK); cleared on any IF grant and on
//    any cycle with IF_REQ=0.
//  - FSM on response path: RESP_NONE, RESP_IF, RESP_MA. Next state is RESP_IF after IF grant, RESP_MA after MA load
//    grant, and RESP_NONE otherwise (including store grant). Latency is 1: RVALID asserted for exactly 1 cycle while
//    in RESP_IF/RESP_MA. RDATA is MEM_RDATA passthrough; the non-owner's RDATA is 0.
//  - IF_FLUSH: in RESP_IF, IF_RVALID is forced 0 the same cycle. A grant issued in the flush cycle is still valid:
//    the requester must drop IF_REQ during flush if the grant is unwanted.
//  - Store grant: MEM_WE = MA_BE, no response. Store with MA_BE=0 is granted and performs no write.
//  - Back-to-back: a new grant is allowed in the same cycle a response returns; full throughput = 1 access/cycle.
//  - Reset values: IF_GNT/MA_GNT/RVALIDs/MEM_EN/MEM_WE = 0, RDATAs = 0, FSM = RESP_NONE, streak_cnt = 0,
//    perf counters = 0. A reset during a pending read drops it; no RVALID appears after reset.
//  - Address bits above ADDR_W+1 are ignored (wrap-around); bits [1:0] are ignored.
// CONFIGURATION
//  RISCOFFEE_ARB_PERF_EN defined:
//    PERF_IF_WAIT and PERF_MA_GNT are free-running 32b counters that wrap at 2^32.
//  Not defined:
//    Both ports are tied to 0; no counter flops.
// STRUCTURE
//  - riscoffee_pkg holds the resp_owner_e enum (RESP_NONE/RESP_IF/RESP_MA) and the mem_req_t struct (addr, we, be,
//    wdata). Both are shared with riscoffee_ram and the core.
//  - No sub-modules. The arbitration logic and response FSM are single always_comb/always_ff pairs.
// TESTING
//  - IF_REQ=1 alone at 0x8000 -> IF_GNT=1, MEM_ADDR=0x2000; next cycle IF_RVALID=1, IF_RDATA=MEM_RDATA.
//  - IF_REQ=1 and MA load at 0x100 simultaneously -> MA_GNT=1, IF_GNT=0; next cycle MA_RVALID=1, IF_RVALID=0.
//  - Continuous contention with MAX_MA_STREAK=4 -> grant pattern MA,MA,MA,MA,IF, then repeats.
//  - MA store, BE=4'b0011, WDATA=0xDEADBEEF -> MEM_WE=4'b0011 same cycle; no MA_RVALID follows.
//  - IF granted, then IF_FLUSH=1 next cycle -> IF_RVALID=0.
//  - IF read granted, then RST_N=0 next edge -> IF_RVALID=0 and PERF counters=0.

Source files
------------

// File: rtl/riscoffee_pkg.sv
// Types shared by the memory arbiter, riscoffee_ram and the core.
// Read-response owner and the RAM request struct.
package riscoffee_pkg;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_MA   = 2'd2
    } resp_owner_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_req_t;

    localparam int STREAK_W = 4;

endpackage

// File: rtl/riscoffee_mem_arbiter.sv
// IF/MA arbiter for the shared single-port RAM: MA priority, IF starvation guard,
// 1-cycle read-response routing. Optional perf counters under RISCOFFEE_ARB_PERF_EN.
module riscoffee_mem_arbiter
    import riscoffee_pkg::*;
#(
    parameter int ADDR_W        = 14,
    parameter int MAX_MA_STREAK = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IF_REQ,
    input  logic [31:0]       IF_ADDR,
    input  logic              IF_FLUSH,
    output logic              IF_GNT,
    output logic              IF_RVALID,
    output logic [31:0]       IF_RDATA,
    input  logic              MA_REQ,
    input  logic              MA_WE,
    input  logic [3:0]        MA_BE,
    input  logic [31:0]       MA_ADDR,
    input  logic [31:0]       MA_WDATA,
    output logic              MA_GNT,
    output logic              MA_RVALID,
    output logic [31:0]       MA_RDATA,
    output logic              MEM_EN,
    output logic [3:0]        MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [31:0]       MEM_WDATA,
    input  logic [31:0]       MEM_RDATA,
    output logic [31:0]       PERF_IF_WAIT,
    output logic [31:0]       PERF_MA_GNT
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_MA_STREAK);

    resp_owner_e         resp_q, resp_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                if_gnt, ma_gnt;
    mem_req_t            req;

    always_comb begin
        if_gnt    = 1'b0;
        ma_gnt    = 1'b0;
        streak_d  = streak_q;
        resp_d    = RESP_NONE;
        req       = '0;
        IF_RVALID = 1'b0;
        IF_RDATA  = '0;
        MA_RVALID = 1'b0;
        MA_RDATA  = '0;

        // Grants are held off while reset is asserted so nothing reaches the RAM.
        if (RST_N) begin
            if (IF_REQ && (!MA_REQ || streak_q == STREAK_MAX)) begin
                if_gnt = 1'b1;
            end else if (MA_REQ) begin
                ma_gnt = 1'b1;
            end
        end

        if (!IF_REQ || if_gnt) begin
            streak_d = '0;
        end else if (ma_gnt && streak_q < STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
        end

        if (if_gnt) begin
            req.addr = IF_ADDR;
            resp_d   = RESP_IF;
        end else if (ma_gnt) begin
            req.addr  = MA_ADDR;
            req.we    = MA_WE;
            req.be    = MA_BE;
            req.wdata = MA_WDATA;
            resp_d    = MA_WE ? RESP_NONE : RESP_MA;
        end

        if (RST_N) begin
            unique case (resp_q)
                RESP_IF: begin
                    IF_RVALID = !IF_FLUSH;
                    IF_RDATA  = MEM_RDATA;
                end
                RESP_MA: begin
                    MA_RVALID = 1'b1;
                    MA_RDATA  = MEM_RDATA;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            resp_q   <= RESP_NONE;
            streak_q <= '0;
        end else begin
            resp_q   <= resp_d;
            streak_q <= streak_d;
        end
    end

    assign IF_GNT    = if_gnt;
    assign MA_GNT    = ma_gnt;
    assign MEM_EN    = if_gnt | ma_gnt;
    assign MEM_WE    = req.we ? req.be : 4'b0000;
    assign MEM_ADDR  = req.addr[ADDR_W+1:2];
    assign MEM_WDATA = req.wdata;

    // Byte-offset and out-of-range address bits are dropped on purpose (wrap-around).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req.addr[31:ADDR_W+2], req.addr[1:0]};

`ifdef RISCOFFEE_ARB_PERF_EN
    logic [31:0] perf_if_wait_q, perf_ma_gnt_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            perf_if_wait_q <= '0;
            perf_ma_gnt_q  <= '0;
        end else begin
            if (IF_REQ && !if_gnt) perf_if_wait_q <= perf_if_wait_q + 32'd1;
            if (ma_gnt)            perf_ma_gnt_q  <= perf_ma_gnt_q + 32'd1;
        end
    end

    assign PERF_IF_WAIT = perf_if_wait_q;
    assign PERF_MA_GNT  = perf_ma_gnt_q;
`else
    assign PERF_IF_WAIT = '0;
    assign PERF_MA_GNT  = '0;
`endif

endmodule

// File: tb/tb_riscoffee_mem_arbiter.sv
// Directed bench for riscoffee_mem_arbiter with a RAM model and a response scoreboard.
// Perf-counter expectations follow RISCOFFEE_ARB_PERF_EN.
module tb_riscoffee_mem_arbiter;
    import riscoffee_pkg::*;

    localparam int ADDR_W = 14;

    typedef struct {
        resp_owner_e own;
        logic [31:0] data;
    } exp_t;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              IF_REQ, IF_FLUSH, IF_GNT, IF_RVALID;
    logic [31:0]       IF_ADDR, IF_RDATA;
    logic              MA_REQ, MA_WE, MA_GNT, MA_RVALID;
    logic [3:0]        MA_BE;
    logic [31:0]       MA_ADDR, MA_WDATA, MA_RDATA;
    logic              MEM_EN;
    logic [3:0]        MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [31:0]       MEM_WDATA;
    logic [31:0]       MEM_RDATA = 32'h0;
    logic [31:0]       PERF_IF_WAIT, PERF_MA_GNT;

    int    errors = 0;
    int    checks = 0;
    exp_t  sb[$];
    int    exp_if_wait = 0;
    int    exp_ma_gnt  = 0;

    riscoffee_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_MA_STREAK(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_FLUSH(IF_FLUSH), .IF_GNT(IF_GNT),
        .IF_RVALID(IF_RVALID), .IF_RDATA(IF_RDATA),
        .MA_REQ(MA_REQ), .MA_WE(MA_WE), .MA_BE(MA_BE), .MA_ADDR(MA_ADDR),
        .MA_WDATA(MA_WDATA), .MA_GNT(MA_GNT), .MA_RVALID(MA_RVALID), .MA_RDATA(MA_RDATA),
        .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA), .PERF_IF_WAIT(PERF_IF_WAIT), .PERF_MA_GNT(PERF_MA_GNT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] ram_f(input logic [ADDR_W-1:0] a);
        return 32'hC0FFEE00 ^ {4'h0, a, a};
    endfunction

    // RAM model: registered read, data depends only on the word address.
    always @(posedge CLK) begin
        if (MEM_EN && MEM_WE == 4'b0000) MEM_RDATA <= ram_f(MEM_ADDR);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rst, input logic ifr, input logic [31:0] ifa, input logic fl,
                       input logic mar, input logic mawe, input logic [3:0] mabe,
                       input logic [31:0] maa, input logic [31:0] mawd,
                       input logic eig, input logic emg, input string tag);
        exp_t e;
        @(negedge CLK);
        RST_N = rst; IF_REQ = ifr; IF_ADDR = ifa; IF_FLUSH = fl;
        MA_REQ = mar; MA_WE = mawe; MA_BE = mabe; MA_ADDR = maa; MA_WDATA = mawd;
        #1;
        if (sb.size() > 0) e = sb.pop_front();
        else e = '{own: RESP_NONE, data: 32'h0};

        chk({tag, ".if_gnt"}, {31'b0, IF_GNT}, {31'b0, eig});
        chk({tag, ".ma_gnt"}, {31'b0, MA_GNT}, {31'b0, emg});
        chk({tag, ".mem_en"}, {31'b0, MEM_EN}, {31'b0, eig | emg});
        chk({tag, ".mem_we"}, {28'b0, MEM_WE}, (emg && mawe) ? {28'b0, mabe} : 32'h0);
        if (eig) chk({tag, ".mem_addr"}, {18'b0, MEM_ADDR}, {18'b0, ifa[ADDR_W+1:2]});
        if (emg) chk({tag, ".mem_addr"}, {18'b0, MEM_ADDR}, {18'b0, maa[ADDR_W+1:2]});
        if (emg && mawe) chk({tag, ".mem_wdata"}, MEM_WDATA, mawd);

        chk({tag, ".if_rvalid"}, {31'b0, IF_RVALID}, {31'b0, rst && e.own == RESP_IF && !fl});
        chk({tag, ".if_rdata"}, IF_RDATA, (rst && e.own == RESP_IF) ? e.data : 32'h0);
        chk({tag, ".ma_rvalid"}, {31'b0, MA_RVALID}, {31'b0, rst && e.own == RESP_MA});
        chk({tag, ".ma_rdata"}, MA_RDATA, (rst && e.own == RESP_MA) ? e.data : 32'h0);

`ifdef RISCOFFEE_ARB_PERF_EN
        chk({tag, ".perf_if_wait"}, PERF_IF_WAIT, 32'(exp_if_wait));
        chk({tag, ".perf_ma_gnt"}, PERF_MA_GNT, 32'(exp_ma_gnt));
`else
        chk({tag, ".perf_if_wait"}, PERF_IF_WAIT, 32'h0);
        chk({tag, ".perf_ma_gnt"}, PERF_MA_GNT, 32'h0);
`endif

        if (rst && eig)               sb.push_back('{own: RESP_IF, data: ram_f(ifa[ADDR_W+1:2])});
        else if (rst && emg && !mawe) sb.push_back('{own: RESP_MA, data: ram_f(maa[ADDR_W+1:2])});
        else                          sb.push_back('{own: RESP_NONE, data: 32'h0});

        if (!rst) begin
            exp_if_wait = 0;
            exp_ma_gnt  = 0;
        end else begin
            if (ifr && !eig) exp_if_wait++;
            if (emg)         exp_ma_gnt++;
        end
    endtask

    task automatic idle(input string tag);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        RST_N = 1'b0; IF_REQ = 1'b0; IF_ADDR = '0; IF_FLUSH = 1'b0;
        MA_REQ = 1'b0; MA_WE = 1'b0; MA_BE = '0; MA_ADDR = '0; MA_WDATA = '0;

        cyc(1'b0, 1'b1, 32'h8000, 1'b0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1'b0, 1'b0, "rst0");
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, "rst1");

        cyc(1'b1, 1'b1, 32'h8000, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, "if_alone");
        idle("if_resp");

        cyc(1'b1, 1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1'b0, 1'b1, "ma_prio");
        idle("ma_resp");

        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 4'h0, 32'h200, 32'h0,
                (i % 5) == 4, (i % 5) != 4, $sformatf("streak%0d", i));
        end
        idle("streak_drain");

        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h300, 32'hDEADBEEF, 1'b0, 1'b1, "store");
        idle("store_noresp");
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 4'b0000, 32'h304, 32'h12345678, 1'b0, 1'b1, "store_be0");

        cyc(1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, "flush_gnt");
        cyc(1'b1, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, "flush");
        idle("post_flush");

        cyc(1'b1, 1'b1, 32'hFFFF8007, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, "wrap");
        cyc(1'b1, 1'b1, 32'h1C, 1'b0, 1'b1, 1'b0, 4'h0, 32'hABCD0010, 32'h0, 1'b0, 1'b1, "b2b_ma");
        idle("b2b_resp");

        cyc(1'b1, 1'b1, 32'h8000, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, "pre_rst");
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, "rst_drop");
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, "rst_hold");
        idle("after_rst0");
        idle("after_rst1");

        @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
